// File: rtl/aes_pkg.sv
// Shared AES definitions: FIPS-197 forward/inverse S-box tables and the
// engine FSM state type, reused by the SubBytes / InvSubBytes datapaths.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lane.sv
// One combinational byte substitution lane: forward S-box (mode 0) or
// inverse S-box (mode 1).
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic       mode_i,
  output logic [7:0] byte_o
);

  assign byte_o = mode_i ? INV_SBOX[byte_i] : SBOX[byte_i];

endmodule

// File: rtl/sbox_engine.sv
// Iterative SubBytes / InvSubBytes engine: captures a SIZE-byte block and
// substitutes LANES bytes per cycle in place, then holds the result until taken.
module sbox_engine
  import aes_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int LANES = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              v_i,
  output logic              ready_o,
  input  logic              mode_i,
  input  logic [SIZE*8-1:0] block_i,
  output logic              v_o,
  input  logic              yumi_i,
  output logic [SIZE*8-1:0] block_o
);

  localparam int STEPS = SIZE / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if (SIZE % LANES != 0) begin : g_bad_params
    $error("sbox_engine: SIZE must be a multiple of LANES");
  end

  state_e            r_state;
  logic [CW-1:0]     r_step;
  logic              r_mode;
  logic [SIZE*8-1:0] r_block;

  logic [7:0]        w_lane_in  [LANES];
  logic [7:0]        w_lane_out [LANES];
  logic [SIZE*8-1:0] w_next_block;

  // Lane l of step c works on byte c*LANES + l of the working register.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_in[l] = r_block[(int'(r_step) * LANES + l) * 8 +: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .byte_i (w_lane_in[l]),
      .mode_i (r_mode),
      .byte_o (w_lane_out[l])
    );
  end

  always_comb begin
    // NOTE: full default before the partial overwrite keeps this purely combinational (no latch).
    w_next_block = r_block;
    for (int l = 0; l < LANES; l++) begin
      w_next_block[(int'(r_step) * LANES + l) * 8 +: 8] = w_lane_out[l];
    end
  end

  // NOTE: the working register is reset too, since block_o must read 0 after reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_mode  <= 1'b0;
      r_block <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (r_state)
        ST_IDLE: begin
          if (v_i) begin
            r_block <= block_i;
            r_mode  <= mode_i;
            r_step  <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_block <= w_next_block;
          if (r_step == LAST_STEP) begin
            r_state <= ST_DONE;
          end else begin
            r_step <= r_step + CW'(1);
          end
        end
        ST_DONE: begin
          if (yumi_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o = (r_state == ST_IDLE);
  assign v_o     = (r_state == ST_DONE);
  assign block_o = r_block;

endmodule

// File: tb/tb_sbox_engine.sv
// Directed and randomized checks of sbox_engine: known-answer vectors, latency,
// backpressure, reset abort, and a LANES sweep on separate instances.
module tb_sbox_engine;
  import aes_pkg::*;

  localparam int SIZE = 16;
  localparam int W    = SIZE * 8;

  localparam logic [W-1:0] VEC_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [W-1:0] VEC_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         v_i, mode_i, yumi_i;
  logic [W-1:0] block_i;
  logic         ready_o, v_o;
  logic [W-1:0] block_o;

  logic         v2, mode2, yumi2;
  logic [W-1:0] blk2;
  logic         sw_ready [3];
  logic         sw_v     [3];
  logic [W-1:0] sw_block [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  sbox_engine #(.SIZE(SIZE), .LANES(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .mode_i(mode_i),
    .block_i(block_i), .v_o(v_o), .yumi_i(yumi_i), .block_o(block_o)
  );

  sbox_engine #(.SIZE(SIZE), .LANES(1)) u_l1 (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v2), .ready_o(sw_ready[0]), .mode_i(mode2),
    .block_i(blk2), .v_o(sw_v[0]), .yumi_i(yumi2), .block_o(sw_block[0])
  );

  sbox_engine #(.SIZE(SIZE), .LANES(2)) u_l2 (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v2), .ready_o(sw_ready[1]), .mode_i(mode2),
    .block_i(blk2), .v_o(sw_v[1]), .yumi_i(yumi2), .block_o(sw_block[1])
  );

  sbox_engine #(.SIZE(SIZE), .LANES(16)) u_l16 (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v2), .ready_o(sw_ready[2]), .mode_i(mode2),
    .block_i(blk2), .v_o(sw_v[2]), .yumi_i(yumi2), .block_o(sw_block[2])
  );

  task automatic check_blk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] b, input logic m);
    logic [W-1:0] r;
    for (int k = 0; k < SIZE; k++) begin
      r[8*k +: 8] = m ? INV_SBOX[b[8*k +: 8]] : SBOX[b[8*k +: 8]];
    end
    return r;
  endfunction

  // Handshake one block into the main instance; lat counts edges from the
  // capturing edge up to the first cycle with v_o high (bounded).
  task automatic send_block(input logic [W-1:0] blk, input logic m, output int lat);
    v_i     = 1'b1;
    block_i = blk;
    mode_i  = m;
    @(posedge clk_i); #1;
    v_i     = 1'b0;
    block_i = ~blk;
    mode_i  = ~m;
    lat     = 1;
    while (v_o !== 1'b1 && lat < 40) begin
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic take_result();
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
  endtask

  initial begin
    int           lat;
    int           sw_lat [3];
    logic [W-1:0] rblk;
    logic         rm;

    reset_i = 1'b1;
    v_i = 1'b0; mode_i = 1'b0; yumi_i = 1'b0; block_i = '0;
    v2 = 1'b0; mode2 = 1'b0; yumi2 = 1'b0; blk2 = '0;

    #2;
    check_bit("rst_ready", ready_o, 1'b1);
    check_bit("rst_v", v_o, 1'b0);
    check_blk("rst_block", block_o, '0);
    #20;
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    check_bit("post_rst_ready", ready_o, 1'b1);
    check_blk("post_rst_block", block_o, '0);

    // Known-answer vectors
    send_block(VEC_IN, 1'b0, lat);
    check_int("fwd_latency", lat, 5);
    check_blk("fwd_vector", block_o, VEC_OUT);
    check_bit("done_ready", ready_o, 1'b0);
    take_result();
    check_bit("yumi_ready", ready_o, 1'b1);
    check_bit("yumi_v", v_o, 1'b0);

    send_block(VEC_OUT, 1'b1, lat);
    check_int("inv_latency", lat, 5);
    check_blk("inv_vector", block_o, VEC_IN);
    take_result();

    send_block('0, 1'b0, lat);
    check_blk("fwd_zero", block_o, {16{8'h63}});
    take_result();

    send_block({16{8'h16}}, 1'b1, lat);
    check_blk("inv_16", block_o, {16{8'hff}});
    take_result();

    // yumi in IDLE ignored; v_i / yumi / input changes in BUSY ignored
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
    check_bit("idle_yumi_ready", ready_o, 1'b1);
    check_bit("idle_yumi_v", v_o, 1'b0);
    v_i = 1'b1; block_i = VEC_IN; mode_i = 1'b0;
    @(posedge clk_i); #1;
    block_i = '0; mode_i = 1'b1; yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check_bit("busy_ready", ready_o, 1'b0);
      check_bit("busy_v", v_o, 1'b0);
    end
    v_i = 1'b0; yumi_i = 1'b0;
    @(posedge clk_i); #1;
    check_bit("busy_ignore_v", v_o, 1'b1);
    check_blk("busy_ignore_block", block_o, VEC_OUT);

    // Backpressure: hold result for 20 cycles while inputs toggle
    for (int i = 0; i < 20; i++) begin
      v_i     = 1'($urandom);
      block_i = {$urandom, $urandom, $urandom, $urandom};
      mode_i  = 1'($urandom);
      @(posedge clk_i); #1;
      check_blk("hold_block", block_o, VEC_OUT);
      check_bit("hold_ready", ready_o, 1'b0);
      check_bit("hold_v", v_o, 1'b1);
    end
    v_i = 1'b0;
    take_result();
    check_bit("hold_release_ready", ready_o, 1'b1);

    // Reset after two BUSY steps discards the block
    v_i = 1'b1; block_i = VEC_IN; mode_i = 1'b0;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    #2 reset_i = 1'b1;
    #1;
    check_bit("abort_ready", ready_o, 1'b1);
    check_bit("abort_v", v_o, 1'b0);
    check_blk("abort_block", block_o, '0);
    #2 reset_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      check_bit("abort_no_v", v_o, 1'b0);
    end
    send_block(VEC_IN, 1'b0, lat);
    check_int("abort_fresh_latency", lat, 5);
    check_blk("abort_fresh_block", block_o, VEC_OUT);
    take_result();

    // LANES sweep on the 1-, 2- and 16-lane instances
    for (int i = 0; i < 3; i++) sw_lat[i] = 0;
    v2 = 1'b1; blk2 = VEC_IN; mode2 = 1'b0;
    @(posedge clk_i); #1;
    v2 = 1'b0; blk2 = '0; mode2 = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (sw_v[i] === 1'b1 && sw_lat[i] == 0) sw_lat[i] = cyc;
      end
      @(posedge clk_i); #1;
    end
    check_int("lanes1_latency", sw_lat[0], 17);
    check_int("lanes2_latency", sw_lat[1], 9);
    check_int("lanes16_latency", sw_lat[2], 2);
    check_blk("lanes1_block", sw_block[0], VEC_OUT);
    check_blk("lanes2_block", sw_block[1], VEC_OUT);
    check_blk("lanes16_block", sw_block[2], VEC_OUT);
    yumi2 = 1'b1;
    @(posedge clk_i); #1;
    yumi2 = 1'b0;
    check_bit("lanes1_ready", sw_ready[0], 1'b1);
    check_bit("lanes16_ready", sw_ready[2], 1'b1);

    // Random mixed-mode blocks against the table model
    for (int n = 0; n < 1000; n++) begin
      rblk = {$urandom, $urandom, $urandom, $urandom};
      rm   = 1'($urandom);
      send_block(rblk, rm, lat);
      check_int("rand_latency", lat, 5);
      check_blk("rand_block", block_o, model(rblk, rm));
      take_result();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
